// File: rtl/ctrl_pkg.sv
// ctrl_pkg
// Shared constants for the multi-cycle RV32I control unit: FSM state codes,
// RV32I major opcodes, ALU operation selects, ALU operand selects,
// write-back selects and fault codes. There are no ports; the controller
// and its timer import this package.
package ctrl_pkg;

  // FSM state codes, kept as plain constants for legacy tools
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_EXEC_R   = 4'd2;
  localparam logic [3:0] S_EXEC_I   = 4'd3;
  localparam logic [3:0] S_EXEC_LUI = 4'd4;
  localparam logic [3:0] S_MEM_ADDR = 4'd5;
  localparam logic [3:0] S_MEM_RD   = 4'd6;
  localparam logic [3:0] S_MEM_WR   = 4'd7;
  localparam logic [3:0] S_WB_ALU   = 4'd8;
  localparam logic [3:0] S_WB_MEM   = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_JAL      = 4'd11;
  localparam logic [3:0] S_TRAP     = 4'd12;

  // RV32I major opcodes, IR[6:0]
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_SUB    = 2'b01;
  localparam logic [1:0] ALU_OP_RFUNCT = 2'b10;
  localparam logic [1:0] ALU_OP_IFUNCT = 2'b11;

  localparam logic [1:0] SRC_A_PC   = 2'b00;
  localparam logic [1:0] SRC_A_RS1  = 2'b01;
  localparam logic [1:0] SRC_A_ZERO = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  localparam logic [1:0] WB_SEL_ALUOUT = 2'b00;
  localparam logic [1:0] WB_SEL_MDR    = 2'b01;
  localparam logic [1:0] WB_SEL_PC4    = 2'b10;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  // States that hold a memory request and wait on mem_ready
  function automatic logic is_wait_state(input logic [3:0] s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer
// Counts consecutive cycles spent waiting on mem_ready.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   clear       zero the count (takes priority over inc)
//   inc         one more waiting cycle has elapsed
//   expired     the cycle in progress is the MEM_TIMEOUT-th waiting cycle
module mem_wait_timer
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  logic [TW-1:0] count;

  // count holds the number of earlier waiting cycles, so the trap fires in
  // the same cycle the total reaches MEM_TIMEOUT; the count never has to
  // advance past MEM_TIMEOUT-1.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == TW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller
// FSM control unit for the multi-cycle RV32I core. It sequences
// FETCH/DECODE/EXECUTE/MEM/WB, stalls on mem_ready, and enters a sticky
// TRAP on an illegal opcode or a memory wait timeout.
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   opcode         IR[6:0], valid from DECODE onward
//   br_taken       branch-compare result from the datapath
//   mem_ready      memory completed the current access this cycle
//   pc_write, ir_write, alu_src_a, alu_src_b, alu_op, mem_read, mem_write,
//   iord, mem_to_reg, reg_write, pc_src   datapath/memory control strobes
//   trap, fault_code   sticky fault flag and cause
// Optional feature: defining CTRL_PERF_CNT_EN adds the cycle_cnt and
// instret_cnt performance counters (parameter CNT_W).
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
`ifdef CTRL_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       br_taken,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic [1:0] mem_to_reg,
  output logic       reg_write,
  output logic       pc_src,
  output logic       trap,
  output logic [1:0] fault_code
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
`endif
);

  logic [3:0] state, next_state;
  logic [1:0] fault_q, fault_next;
  logic       fault_set;
  logic       wait_inc, expired;

  // Only cycles that hold a request without mem_ready advance the timer;
  // every other cycle clears it, so each access starts from zero.
  assign wait_inc = is_wait_state(state) && !mem_ready;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (!wait_inc),
    .inc    (wait_inc),
    .expired(expired)
  );

  // Next state and control decode. Strobes depend on the state plus
  // mem_ready/br_taken; register and PC writes are only raised once
  // mem_ready arrives. Reset forces every output low in the same cycle,
  // which also aborts an in-flight access.
  always_comb begin
    next_state = state;
    fault_set  = 1'b0;
    fault_next = FAULT_NONE;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    alu_op     = ALU_OP_ADD;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    mem_to_reg = WB_SEL_ALUOUT;
    reg_write  = 1'b0;
    pc_src     = 1'b0;
    trap       = 1'b0;
    fault_code = fault_q;

    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_a = SRC_A_PC;
        alu_src_b = SRC_B_FOUR;
        alu_op    = ALU_OP_ADD;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = S_DECODE;
        end else if (expired) begin
          next_state = S_TRAP;
          fault_set  = 1'b1;
          fault_next = FAULT_TIMEOUT;
        end
      end
      S_DECODE: begin
        alu_src_a = SRC_A_PC;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALU_OP_ADD;
        case (opcode)
          OP_R:               next_state = S_EXEC_R;
          OP_I:               next_state = S_EXEC_I;
          OP_LOAD, OP_STORE:  next_state = S_MEM_ADDR;
          OP_BRANCH:          next_state = S_BRANCH;
          OP_JAL:             next_state = S_JAL;
          OP_LUI:             next_state = S_EXEC_LUI;
          default: begin
            next_state = S_TRAP;
            fault_set  = 1'b1;
            fault_next = FAULT_ILLEGAL;
          end
        endcase
      end
      S_EXEC_R: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_RS2;
        alu_op     = ALU_OP_RFUNCT;
        next_state = S_WB_ALU;
      end
      S_EXEC_I: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_IMM;
        alu_op     = ALU_OP_IFUNCT;
        next_state = S_WB_ALU;
      end
      S_EXEC_LUI: begin
        alu_src_a  = SRC_A_ZERO;
        alu_src_b  = SRC_B_IMM;
        alu_op     = ALU_OP_ADD;
        next_state = S_WB_ALU;
      end
      S_MEM_ADDR: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_IMM;
        alu_op     = ALU_OP_ADD;
        next_state = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD, S_MEM_WR: begin
        mem_read  = (state == S_MEM_RD);
        mem_write = (state == S_MEM_WR);
        iord      = 1'b1;
        if (mem_ready) begin
          next_state = (state == S_MEM_RD) ? S_WB_MEM : S_FETCH;
        end else if (expired) begin
          next_state = S_TRAP;
          fault_set  = 1'b1;
          fault_next = FAULT_TIMEOUT;
        end
      end
      S_WB_ALU: begin
        reg_write  = 1'b1;
        mem_to_reg = WB_SEL_ALUOUT;
        next_state = S_FETCH;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = WB_SEL_MDR;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_RS2;
        alu_op     = ALU_OP_SUB;
        pc_src     = 1'b1;
        pc_write   = br_taken;
        next_state = S_FETCH;
      end
      S_JAL: begin
        reg_write  = 1'b1;
        mem_to_reg = WB_SEL_PC4;
        pc_src     = 1'b1;
        pc_write   = 1'b1;
        next_state = S_FETCH;
      end
      S_TRAP: begin
        trap = 1'b1;
      end
      default: begin
        next_state = S_FETCH;
      end
    endcase

    if (reset) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      alu_src_a  = SRC_A_PC;
      alu_src_b  = SRC_B_RS2;
      alu_op     = ALU_OP_ADD;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      mem_to_reg = WB_SEL_ALUOUT;
      reg_write  = 1'b0;
      pc_src     = 1'b0;
      trap       = 1'b0;
      fault_code = FAULT_NONE;
    end
  end

  // State and sticky fault cause; only reset can leave TRAP.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      fault_q <= FAULT_NONE;
    end else begin
      state <= next_state;
      if (fault_set) begin
        fault_q <= fault_next;
      end
    end
  end

`ifdef CTRL_PERF_CNT_EN
  // Both counters freeze in TRAP; an instruction retires whenever the
  // FSM returns to FETCH from another state.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else if (state != S_TRAP) begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if ((next_state == S_FETCH) && (state != S_FETCH)) begin
        instret_cnt <= instret_cnt + 1'b1;
      end
    end
  end
`endif

endmodule
